// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 register-class execution unit.
package chip8_pkg;

  typedef enum logic [3:0] {
    CLS_SE_IMM,
    CLS_SNE_IMM,
    CLS_SE_REG,
    CLS_LD_IMM,
    CLS_ADD_IMM,
    CLS_ALU,
    CLS_SNE_REG,
    CLS_LD_I,
    CLS_JP_V0,
    CLS_RND,
    CLS_ADD_I,
    CLS_BAD
  } op_class_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_X,
    ST_WAIT_X,
    ST_RD_Y,
    ST_WAIT_Y,
    ST_RD_IH,
    ST_WAIT_IH,
    ST_RD_IL,
    ST_WAIT_IL,
    ST_WR_A,
    ST_WR_B,
    ST_DONE
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_PARSE = 2'd1;
  localparam logic [1:0] ERR_STATE = 2'd2;
  localparam logic [1:0] ERR_EXEC  = 2'd3;

  localparam int unsigned REG_VF = 15;
  localparam int unsigned REG_IH = 16;
  localparam int unsigned REG_IL = 17;

  function automatic op_class_e decode_op(input logic [15:0] op);
    op_class_e c;
    c = CLS_BAD;
    case (op[15:12])
      4'h3: c = CLS_SE_IMM;
      4'h4: c = CLS_SNE_IMM;
      4'h5: if (op[3:0] == 4'h0) c = CLS_SE_REG;
      4'h6: c = CLS_LD_IMM;
      4'h7: c = CLS_ADD_IMM;
      4'h8: if (op[3:0] inside {[4'h0:4'h7], 4'hE}) c = CLS_ALU;
      4'h9: if (op[3:0] == 4'h0) c = CLS_SNE_REG;
      4'hA: c = CLS_LD_I;
      4'hB: c = CLS_JP_V0;
      4'hC: c = CLS_RND;
      4'hF: if (op[7:0] == 8'h1E) c = CLS_ADD_I;
      default: c = CLS_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/chip8_reg_exec_if.sv
// Ready/valid port to the byte-wide register BRAM (V0-VF, IH, IL).
interface chip8_reg_exec_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] mem_addr_out;
  logic                  mem_we_out;
  logic                  mem_valid_out;
  logic [7:0]            mem_data_out;
  logic                  mem_ready_in;
  logic                  mem_valid_in;
  logic [7:0]            mem_data_in;

  modport master (
    output mem_addr_out, mem_we_out, mem_valid_out, mem_data_out,
    input  mem_ready_in, mem_valid_in, mem_data_in
  );

  modport slave (
    input  mem_addr_out, mem_we_out, mem_valid_out, mem_data_out,
    output mem_ready_in, mem_valid_in, mem_data_in
  );
endinterface

// File: rtl/chip8_alu.sv
// Combinational ALU for 8xyN and 7xkk (7xkk passes kk on vy_i with imm_add_i set).
module chip8_alu (
  input  logic [3:0] op_i,
  input  logic       imm_add_i,
  input  logic [7:0] vx_i,
  input  logic [7:0] vy_i,
  input  logic       vf_reset_i,
  input  logic       shift_vy_i,
  output logic [7:0] result_o,
  output logic       flag_o,
  output logic       flag_we_o
);
  logic [8:0] sum9;
  logic [7:0] src;

  always_comb begin
    sum9      = {1'b0, vx_i} + {1'b0, vy_i};
    src       = shift_vy_i ? vy_i : vx_i;
    result_o  = vx_i;
    flag_o    = 1'b0;
    flag_we_o = 1'b0;
    if (imm_add_i) begin
      result_o = sum9[7:0];
    end else begin
      case (op_i)
        4'h0: result_o = vy_i;
        4'h1: begin result_o = vx_i | vy_i; flag_we_o = vf_reset_i; end
        4'h2: begin result_o = vx_i & vy_i; flag_we_o = vf_reset_i; end
        4'h3: begin result_o = vx_i ^ vy_i; flag_we_o = vf_reset_i; end
        4'h4: begin result_o = sum9[7:0]; flag_o = sum9[8]; flag_we_o = 1'b1; end
        4'h5: begin result_o = vx_i - vy_i; flag_o = (vx_i >= vy_i); flag_we_o = 1'b1; end
        4'h6: begin result_o = {1'b0, src[7:1]}; flag_o = src[0]; flag_we_o = 1'b1; end
        4'h7: begin result_o = vy_i - vx_i; flag_o = (vy_i >= vx_i); flag_we_o = 1'b1; end
        4'hE: begin result_o = {src[6:0], 1'b0}; flag_o = src[7]; flag_we_o = 1'b1; end
        default: result_o = vx_i;
      endcase
    end
  end
endmodule

// File: rtl/chip8_reg_exec.sv
// CHIP-8 register-class execution unit: reads operands from the register BRAM,
// writes results (Vx then VF, or IH then IL) and returns the next pc with done.
module chip8_reg_exec
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned REG_ADDR_W     = 5,
  parameter bit          QUIRK_VF_RESET = 1'b1,
  parameter bit          QUIRK_SHIFT_VY = 1'b1,
  parameter bit          QUIRK_JUMP_VX  = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              instr_valid_in,
  output logic              instr_ready_out,
  input  logic [15:0]       opcode_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [7:0]        rnd_in,
  output logic              done_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        error_out,
  chip8_reg_exec_if.master  mem_bus
);
  state_e            state_q, state_d;
  op_class_e         cls_q, cls_d, dec_cls;
  logic [11:0]       op_q, op_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_next;
  logic [7:0]        rnd_q, rnd_d;
  logic [7:0]        vx_q, vx_d, vy_q, vy_d, il_q, il_d;
  logic [3:0]        ih_q, ih_d;
  logic [1:0]        err_q, err_d;

  logic [REG_ADDR_W-1:0] x_addr, y_addr;
  logic [7:0]  kk, alu_res;
  logic [11:0] i_sum;
  logic        alu_flag, alu_flag_we;
  logic        need_y, need_i, need_wa, need_wb;
  state_e      after_x, after_y, after_wa;

  chip8_alu u_alu (
    .op_i       (op_q[3:0]),
    .imm_add_i  (cls_q == CLS_ADD_IMM),
    .vx_i       (vx_q),
    .vy_i       ((cls_q == CLS_ADD_IMM) ? kk : vy_q),
    .vf_reset_i (QUIRK_VF_RESET),
    .shift_vy_i (QUIRK_SHIFT_VY),
    .result_o   (alu_res),
    .flag_o     (alu_flag),
    .flag_we_o  (alu_flag_we)
  );

  always_comb begin
    kk      = op_q[7:0];
    x_addr  = REG_ADDR_W'(op_q[11:8]);
    // Bnnn reuses the Y slot to fetch V0
    y_addr  = (cls_q == CLS_JP_V0) ? '0 : REG_ADDR_W'(op_q[7:4]);
    i_sum   = {ih_q, il_q} + {4'h0, vx_q};
    need_y  = (cls_q inside {CLS_SE_REG, CLS_ALU, CLS_SNE_REG}) ||
              ((cls_q == CLS_JP_V0) && !QUIRK_JUMP_VX);
    need_i  = (cls_q == CLS_ADD_I);
    need_wa = cls_q inside {CLS_LD_IMM, CLS_ADD_IMM, CLS_ALU, CLS_LD_I, CLS_RND, CLS_ADD_I};
    need_wb = ((cls_q == CLS_ALU) && alu_flag_we) || (cls_q inside {CLS_LD_I, CLS_ADD_I});
    after_y  = need_i ? ST_RD_IH : (need_wa ? ST_WR_A : ST_DONE);
    after_x  = need_y ? ST_RD_Y : after_y;
    after_wa = need_wb ? ST_WR_B : ST_DONE;

    pc_next = pc_q;
    case (cls_q)
      CLS_SE_IMM:  if (vx_q == kk)   pc_next = pc_q + ADDR_W'(2);
      CLS_SNE_IMM: if (vx_q != kk)   pc_next = pc_q + ADDR_W'(2);
      CLS_SE_REG:  if (vx_q == vy_q) pc_next = pc_q + ADDR_W'(2);
      CLS_SNE_REG: if (vx_q != vy_q) pc_next = pc_q + ADDR_W'(2);
      CLS_JP_V0:   pc_next = ADDR_W'(op_q) + ADDR_W'(QUIRK_JUMP_VX ? vx_q : vy_q);
      default:     pc_next = pc_q;
    endcase
  end

  always_comb begin
    dec_cls  = decode_op(opcode_in);
    state_d  = state_q;
    cls_d    = cls_q;
    op_d     = op_q;
    pc_d     = pc_q;
    rnd_d    = rnd_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    ih_d     = ih_q;
    il_d     = il_q;
    err_d    = err_q;
    instr_ready_out       = 1'b0;
    done_out              = 1'b0;
    pc_out                = '0;
    mem_bus.mem_addr_out  = '0;
    mem_bus.mem_we_out    = 1'b0;
    mem_bus.mem_valid_out = 1'b0;
    mem_bus.mem_data_out  = '0;

    case (state_q)
      ST_IDLE: begin
        instr_ready_out = 1'b1;
        if (instr_valid_in) begin
          cls_d = dec_cls;
          op_d  = opcode_in[11:0];
          pc_d  = pc_in;
          rnd_d = rnd_in;
          if (dec_cls == CLS_BAD) begin
            state_d = ST_DONE;
            if (err_q == ERR_NONE) err_d = ERR_PARSE;
          end else if (dec_cls inside {CLS_LD_IMM, CLS_LD_I, CLS_RND}) begin
            state_d = ST_WR_A;
          end else begin
            state_d = ST_RD_X;
          end
        end
      end
      ST_RD_X: begin
        mem_bus.mem_addr_out = x_addr;
        if (mem_bus.mem_ready_in) begin
          mem_bus.mem_valid_out = 1'b1;
          state_d = ST_WAIT_X;
        end
      end
      ST_WAIT_X: if (mem_bus.mem_valid_in) begin
        vx_d    = mem_bus.mem_data_in;
        state_d = after_x;
      end
      ST_RD_Y: begin
        mem_bus.mem_addr_out = y_addr;
        if (mem_bus.mem_ready_in) begin
          mem_bus.mem_valid_out = 1'b1;
          state_d = ST_WAIT_Y;
        end
      end
      ST_WAIT_Y: if (mem_bus.mem_valid_in) begin
        vy_d    = mem_bus.mem_data_in;
        state_d = after_y;
      end
      ST_RD_IH: begin
        mem_bus.mem_addr_out = REG_ADDR_W'(REG_IH);
        if (mem_bus.mem_ready_in) begin
          mem_bus.mem_valid_out = 1'b1;
          state_d = ST_WAIT_IH;
        end
      end
      ST_WAIT_IH: if (mem_bus.mem_valid_in) begin
        ih_d    = mem_bus.mem_data_in[3:0];
        state_d = ST_RD_IL;
      end
      ST_RD_IL: begin
        mem_bus.mem_addr_out = REG_ADDR_W'(REG_IL);
        if (mem_bus.mem_ready_in) begin
          mem_bus.mem_valid_out = 1'b1;
          state_d = ST_WAIT_IL;
        end
      end
      ST_WAIT_IL: if (mem_bus.mem_valid_in) begin
        il_d    = mem_bus.mem_data_in;
        state_d = ST_WR_A;
      end
      ST_WR_A: begin
        mem_bus.mem_we_out = 1'b1;
        case (cls_q)
          CLS_LD_IMM: begin mem_bus.mem_addr_out = x_addr; mem_bus.mem_data_out = kk; end
          CLS_RND:    begin mem_bus.mem_addr_out = x_addr; mem_bus.mem_data_out = rnd_q & kk; end
          CLS_LD_I:   begin mem_bus.mem_addr_out = REG_ADDR_W'(REG_IH); mem_bus.mem_data_out = {4'h0, op_q[11:8]}; end
          CLS_ADD_I:  begin mem_bus.mem_addr_out = REG_ADDR_W'(REG_IH); mem_bus.mem_data_out = {4'h0, i_sum[11:8]}; end
          default:    begin mem_bus.mem_addr_out = x_addr; mem_bus.mem_data_out = alu_res; end
        endcase
        if (mem_bus.mem_ready_in) begin
          mem_bus.mem_valid_out = 1'b1;
          state_d = after_wa;
        end
      end
      ST_WR_B: begin
        mem_bus.mem_we_out = 1'b1;
        case (cls_q)
          CLS_LD_I:  begin mem_bus.mem_addr_out = REG_ADDR_W'(REG_IL); mem_bus.mem_data_out = op_q[7:0]; end
          CLS_ADD_I: begin mem_bus.mem_addr_out = REG_ADDR_W'(REG_IL); mem_bus.mem_data_out = i_sum[7:0]; end
          default:   begin mem_bus.mem_addr_out = REG_ADDR_W'(REG_VF); mem_bus.mem_data_out = {7'h00, alu_flag}; end
        endcase
        if (mem_bus.mem_ready_in) begin
          mem_bus.mem_valid_out = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_out = 1'b1;
        pc_out   = pc_next;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        if (err_q == ERR_NONE) err_d = ERR_STATE;
      end
    endcase
  end

  assign error_out = err_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_BAD;
      op_q    <= '0;
      pc_q    <= '0;
      rnd_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      ih_q    <= '0;
      il_q    <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      rnd_q   <= rnd_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      ih_q    <= ih_d;
      il_q    <= il_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_chip8_reg_exec.sv
// Directed bench for chip8_reg_exec: a 1-cycle register memory model plus
// scoreboards of expected register writes and expected next-pc values.
module tb_chip8_reg_exec;
  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] opcode;
  logic [11:0] pc_in;
  logic [7:0]  rnd;
  logic        done;
  logic [11:0] pc_out;
  logic [1:0]  error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  wr_t         wq[$];
  logic [11:0] pcq[$];
  logic [7:0]  model [0:31];
  bit          rd_pend = 1'b0;
  logic [7:0]  rd_data;

  chip8_reg_exec_if #(.REG_ADDR_W(5)) bus ();

  chip8_reg_exec #(
    .ADDR_W(12), .REG_ADDR_W(5),
    .QUIRK_VF_RESET(1'b1), .QUIRK_SHIFT_VY(1'b1), .QUIRK_JUMP_VX(1'b0)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .instr_valid_in  (instr_valid),
    .instr_ready_out (instr_ready),
    .opcode_in       (opcode),
    .pc_in           (pc_in),
    .rnd_in          (rnd),
    .done_out        (done),
    .pc_out          (pc_out),
    .error_out       (error),
    .mem_bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: answers a read on the cycle after the request; writes are scored.
  always @(negedge clk) begin
    bus.mem_valid_in = 1'b0;
    if (rd_pend) begin
      bus.mem_valid_in = 1'b1;
      bus.mem_data_in  = rd_data;
      rd_pend = 1'b0;
    end
    if (rst_n && bus.mem_valid_out && bus.mem_ready_in) begin
      if (bus.mem_we_out) begin
        check("wr_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", 32'(bus.mem_addr_out), 32'(e.a));
          check("wr_data", 32'(bus.mem_data_out), 32'(e.d));
        end
        model[bus.mem_addr_out] = bus.mem_data_out;
      end else begin
        rd_pend = 1'b1;
        rd_data = model[bus.mem_addr_out];
      end
    end
  end

  task automatic exp_wr(input logic [4:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
  endtask

  task automatic run(input logic [15:0] op, input logic [11:0] pc, input logic [7:0] r,
                     input logic [11:0] exp_pc, input int exp_lat, input string tag);
    int c0;
    bit seen;
    pcq.push_back(exp_pc);
    @(negedge clk);
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
    instr_valid = 1'b1;
    opcode = op;
    pc_in  = pc;
    rnd    = r;
    c0     = cyc;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({tag, "_pc"}, 32'(pc_out), 32'(pcq.pop_front()));
        if (exp_lat > 0) check({tag, "_latency"}, cyc - c0 + 1, exp_lat);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    pcq.delete();
    @(negedge clk);
    check({tag, "_writes_left"}, 32'(wq.size()), 32'd0);
    wq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(instr_ready),       32'd1);
    check({tag, "_done"},   32'(done),              32'd0);
    check({tag, "_mvalid"}, 32'(bus.mem_valid_out), 32'd0);
    check({tag, "_mwe"},    32'(bus.mem_we_out),    32'd0);
    check({tag, "_maddr"},  32'(bus.mem_addr_out),  32'd0);
    check({tag, "_mdata"},  32'(bus.mem_data_out),  32'd0);
    check({tag, "_pc"},     32'(pc_out),            32'd0);
    check({tag, "_err"},    32'(error),             32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    opcode = '0;
    pc_in = '0;
    rnd = '0;
    bus.mem_ready_in = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    exp_wr(5'd10, 8'h3C);
    run(16'h6A3C, 12'h200, 8'h00, 12'h200, 3, "ld_imm");

    model[1] = 8'hF0; model[2] = 8'h20;
    exp_wr(5'd1, 8'h10); exp_wr(5'd15, 8'h01);
    run(16'h8124, 12'h202, 8'h00, 12'h202, 0, "add_carry");

    model[1] = 8'hF0; model[2] = 8'h20;
    exp_wr(5'd1, 8'hD0); exp_wr(5'd15, 8'h01);
    run(16'h8125, 12'h204, 8'h00, 12'h204, 0, "sub");

    model[15] = 8'h81;
    exp_wr(5'd15, 8'h40); exp_wr(5'd15, 8'h01);
    run(16'h8FF6, 12'h206, 8'h00, 12'h206, 0, "shr_vf");
    check("shr_vf_final", 32'(model[15]), 32'h01);

    model[3] = 8'h55;
    run(16'h3355, 12'h202, 8'h00, 12'h204, 0, "se_taken");
    run(16'h3356, 12'h202, 8'h00, 12'h202, 0, "se_not_taken");

    model[16] = 8'h0F; model[17] = 8'hFE; model[4] = 8'h05;
    exp_wr(5'd16, 8'h00); exp_wr(5'd17, 8'h03);
    run(16'hF41E, 12'h300, 8'h00, 12'h300, 0, "add_i_wrap");

    model[0] = 8'h02;
    run(16'hB0FF, 12'h400, 8'h00, 12'h101, 0, "jp_v0");

    exp_wr(5'd16, 8'h01); exp_wr(5'd17, 8'h23);
    run(16'hA123, 12'h402, 8'h00, 12'h402, 0, "ld_i");

    exp_wr(5'd10, 8'h50);
    run(16'hCAF0, 12'h404, 8'h5A, 12'h404, 0, "rnd");

    // Stall the memory for five cycles around a 7xkk that wraps past 0xFF
    model[1] = 8'hFE;
    exp_wr(5'd1, 8'h03);
    bus.mem_ready_in = 1'b0;
    fork
      run(16'h7105, 12'h406, 8'h00, 12'h406, 0, "add_imm_stall");
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_no_strobe", 32'(bus.mem_valid_out), 32'd0);
        end
        @(posedge clk);
        #1 bus.mem_ready_in = 1'b1;
      end
    join

    // Reset while waiting for the Vx read data
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = 16'h8124;
    pc_in  = 12'h500;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_mid_reset");
    exp_wr(5'd10, 8'h3C);
    run(16'h6A3C, 12'h502, 8'h00, 12'h502, 3, "ld_imm_after_reset");

    run(16'hE0A2, 12'h600, 8'h00, 12'h600, 2, "bad_op");
    check("bad_op_err", 32'(error), 32'd1);
    exp_wr(5'd10, 8'h3C);
    run(16'h6A3C, 12'h602, 8'h00, 12'h602, 3, "ld_imm_err_sticky");
    check("err_sticky", 32'(error), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
